// File: rtl/rom_seq_counter_if.sv
// Handshake-free control/status bundle for the table-driven sequence counter.
// The master drives step/load/table-write controls; the slave returns state and flags.
interface rom_seq_counter_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             oneshot;
    logic [WIDTH-1:0] term_state;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] state;
    logic             tc;
    logic             done;
    logic [CNT_W-1:0] wrap_cnt;

    modport master (
        output en, load, load_val, oneshot, term_state, wr_en, wr_addr, wr_data,
        input  state, tc, done, wrap_cnt
    );

    modport slave (
        input  en, load, load_val, oneshot, term_state, wr_en, wr_addr, wr_data,
        output state, tc, done, wrap_cnt
    );
endinterface

// File: rtl/rom_seq_counter.sv
// Programmable step sequencer: next state = table[state], runtime-writable table.
// Latency: one cycle from en/load to new state; tc/done registered alongside it.
// No backpressure: en is a plain step strobe, HALT simply ignores it.
module rom_seq_counter #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_STATE = '0,
    parameter int               CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_seq_counter_if.slave  bus
);
    localparam int DEPTH = 2 ** WIDTH;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH-1:0] table_q [DEPTH];
    logic [WIDTH-1:0] table_d [DEPTH];
    logic [WIDTH-1:0] step_val;

    // Table lookup always sees the pre-write contents, giving read-before-write.
    assign step_val = table_q[state_q];

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        tc_d       = 1'b0;
        done_d     = done_q;
        wrap_cnt_d = wrap_cnt_q;

        unique case (fsm_q)
            RUN: begin
                if (bus.load) begin
                    state_d = bus.load_val;
                end else if (bus.en) begin
                    state_d = step_val;
                    if (step_val == bus.term_state) begin
                        tc_d = 1'b1;
                        if (wrap_cnt_q != {CNT_W{1'b1}}) begin
                            wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                        end
                        if (bus.oneshot) begin
                            fsm_d  = HALT;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                if (bus.load) begin
                    state_d = bus.load_val;
                    fsm_d   = RUN;
                    done_d  = 1'b0;
                end else if (!bus.oneshot) begin
                    fsm_d  = RUN;
                    done_d = 1'b0;
                end
            end
            default: begin
                fsm_d = RUN;
            end
        endcase
    end

    always_comb begin
        table_d = table_q;
        if (bus.wr_en) begin
            table_d[bus.wr_addr] = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= RUN;
            state_q    <= RESET_STATE;
            tc_q       <= 1'b0;
            done_q     <= 1'b0;
            wrap_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= WIDTH'((i + 1) % DEPTH);
            end
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            tc_q       <= tc_d;
            done_q     <= done_d;
            wrap_cnt_q <= wrap_cnt_d;
            table_q    <= table_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.tc       = tc_q;
    assign bus.done     = done_q;
    assign bus.wrap_cnt = wrap_cnt_q;
endmodule
